// File: rtl/parity_frame_checker_if.sv
// ----------------------------------------------------------------------------
// parity_frame_checker_if
// Groups the word-stream inputs and the per-word / per-frame result outputs
// of parity_frame_checker into one bundle.
//   master : drives in_valid, in_data, in_par, odd_mode, abort, clr_cnt;
//            observes all results
//   slave  : the checker; observes the inputs, drives out_valid, out_par,
//            word_err, frame_done, frame_err, frame_par, err_cnt, busy
// clk and rst are deliberately not part of the bundle.
// ----------------------------------------------------------------------------
interface parity_frame_checker_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_par;
    logic             odd_mode;
    logic             abort;
    logic             clr_cnt;

    logic             out_valid;
    logic             out_par;
    logic             word_err;
    logic             frame_done;
    logic             frame_err;
    logic             frame_par;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    modport master (
        output in_valid, in_data, in_par, odd_mode, abort, clr_cnt,
        input  out_valid, out_par, word_err, frame_done, frame_err,
               frame_par, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, in_par, odd_mode, abort, clr_cnt,
        output out_valid, out_par, word_err, frame_done, frame_err,
               frame_par, err_cnt, busy
    );
endinterface

// File: rtl/parity_frame_checker.sv
// ----------------------------------------------------------------------------
// parity_frame_checker
// Generates parity for every accepted word, compares it with the received
// parity bit, and groups words into frames of FRAME_LEN words. Per frame it
// reports whether any word was in error and the XOR of all frame data bits.
// A saturating counter tracks word errors across frames.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : parity_frame_checker_if.slave
//          in_valid/in_data/in_par : word, always accepted when in_valid
//          odd_mode                : 1 = odd parity, latched at frame start
//          abort                   : discard the partial frame
//          clr_cnt                 : clear err_cnt
//          out_valid/out_par/word_err : per-word results, 1 cycle later
//          frame_done/frame_err/frame_par : per-frame results
//          err_cnt                 : saturating word-error count
//          busy                    : a frame is partially received
// ----------------------------------------------------------------------------
module parity_frame_checker #(
    parameter int N         = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_frame_checker_if.slave bus
);

    // A single-word frame still needs a 1-bit index to keep the code uniform.
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             acc_par_q, acc_par_d;
    logic             acc_err_q, acc_err_d;
    logic [CNT_W-1:0] cnt_d;

    logic             first_word;
    logic             mode_eff;
    logic             data_xor;
    logic             gen_par;
    logic             werr;
    logic [IDX_W-1:0] idx_eff;
    logic             last_word;
    logic             par_acc_eff;
    logic             err_acc_eff;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would turn this block into a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        acc_par_d = acc_par_q;
        acc_err_d = acc_err_q;
        cnt_d     = bus.err_cnt;

        // abort with a word makes that word the start of a fresh frame, so
        // the old partial frame's mode, index and accumulators are bypassed.
        first_word  = bus.abort || (state_q == IDLE);
        mode_eff    = first_word ? bus.odd_mode : mode_q;
        data_xor    = ^bus.in_data;
        gen_par     = data_xor ^ mode_eff;
        werr        = bus.in_valid && (bus.in_par != gen_par);
        idx_eff     = bus.abort ? '0 : idx_q;
        last_word   = bus.in_valid && (idx_eff == LAST_IDX);
        par_acc_eff = (first_word ? 1'b0 : acc_par_q) ^ data_xor;
        err_acc_eff = (first_word ? 1'b0 : acc_err_q) | werr;

        if (bus.in_valid) begin
            if (last_word) begin
                state_d   = IDLE;
                idx_d     = '0;
                acc_par_d = 1'b0;
                acc_err_d = 1'b0;
            end else begin
                state_d   = ACCUM;
                idx_d     = idx_eff + IDX_W'(1);
                mode_d    = mode_eff;
                acc_par_d = par_acc_eff;
                acc_err_d = err_acc_eff;
            end
        end else if (bus.abort) begin
            state_d   = IDLE;
            idx_d     = '0;
            acc_par_d = 1'b0;
            acc_err_d = 1'b0;
        end

        // Clearing wins over the old count but not over this cycle's error.
        if (bus.clr_cnt) begin
            cnt_d = CNT_W'(werr);
        end else if (werr && (bus.err_cnt != {CNT_W{1'b1}})) begin
            cnt_d = bus.err_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            mode_q         <= 1'b0;
            acc_par_q      <= 1'b0;
            acc_err_q      <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_par    <= 1'b0;
            bus.word_err   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.frame_par  <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mode_q         <= mode_d;
            acc_par_q      <= acc_par_d;
            acc_err_q      <= acc_err_d;
            bus.out_valid  <= bus.in_valid;
            bus.out_par    <= bus.in_valid && gen_par;
            bus.word_err   <= werr;
            bus.frame_done <= last_word;
            bus.err_cnt    <= cnt_d;
            // Frame results hold until the next completed frame.
            if (last_word) begin
                bus.frame_err <= err_acc_eff;
                bus.frame_par <= par_acc_eff;
            end
        end
    end

    assign bus.busy = (state_q == ACCUM);

endmodule

// File: tb/tb_parity_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_parity_frame_checker
// Directed bench for parity_frame_checker. A default instance (N=8,
// FRAME_LEN=4, CNT_W=8) carries most scenarios; a second instance with
// CNT_W=2 shares the same inputs and is held in reset until the
// counter-saturation scenario.
// ----------------------------------------------------------------------------
module tb_parity_frame_checker;

    logic clk;
    logic rst;
    logic rst2;

    int checks = 0;
    int errors = 0;

    parity_frame_checker_if #(.N(8), .CNT_W(8)) bus ();
    parity_frame_checker_if #(.N(8), .CNT_W(2)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_data  = bus.in_data;
    assign bus2.in_par   = bus.in_par;
    assign bus2.odd_mode = bus.odd_mode;
    assign bus2.abort    = bus.abort;
    assign bus2.clr_cnt  = bus.clr_cnt;

    parity_frame_checker #(.N(8), .FRAME_LEN(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    parity_frame_checker #(.N(8), .FRAME_LEN(4), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and return at the next
    // falling edge, where the registered results of that cycle are visible.
    task automatic apply(input logic v, input logic [7:0] d, input logic p,
                         input logic m, input logic ab, input logic clr);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_par   = p;
        bus.odd_mode = m;
        bus.abort    = ab;
        bus.clr_cnt  = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst  = 1'b0;
        rst2 = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_par   = 1'b0;
        bus.odd_mode = 1'b0;
        bus.abort    = 1'b0;
        bus.clr_cnt  = 1'b0;
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_frame_done", bus.frame_done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Parity generation
        apply(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        check("par_03_even_valid", bus.out_valid, 1);
        check("par_03_even", bus.out_par, 0);
        check("par_03_busy", bus.busy, 1);
        apply(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        check("par_07_even", bus.out_par, 1);
        check("par_07_even_werr", bus.word_err, 0);
        // abort with a word starts a new frame, so odd mode is latched here
        apply(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        check("par_07_odd_valid", bus.out_valid, 1);
        check("par_07_odd", bus.out_par, 0);
        check("par_07_odd_werr", bus.word_err, 0);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_only_busy", bus.busy, 0);
        check("abort_only_done", bus.frame_done, 0);
        check("abort_only_valid", bus.out_valid, 0);

        // Clean frame
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_w0_done", bus.frame_done, 0);
        check("clean_w0_busy", bus.busy, 1);
        apply(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_w1_valid", bus.out_valid, 1);
        apply(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_w2_done", bus.frame_done, 0);
        apply(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_w3_valid", bus.out_valid, 1);
        check("clean_done", bus.frame_done, 1);
        check("clean_frame_err", bus.frame_err, 0);
        check("clean_frame_par", bus.frame_par, 0);
        check("clean_err_cnt", bus.err_cnt, 0);
        check("clean_busy", bus.busy, 0);
        idle();
        check("clean_idle_valid", bus.out_valid, 0);
        check("clean_idle_done", bus.frame_done, 0);

        // Error frame; odd_mode toggles after the first word and is ignored
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("err_w0_werr", bus.word_err, 0);
        apply(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        check("err_w1_werr", bus.word_err, 1);
        apply(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
        check("err_w2_werr", bus.word_err, 0);
        check("err_w2_par", bus.out_par, 1);
        apply(1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
        check("err_w3_werr", bus.word_err, 0);
        check("err_done", bus.frame_done, 1);
        check("err_frame_err", bus.frame_err, 1);
        check("err_frame_par", bus.frame_par, 0);
        check("err_err_cnt", bus.err_cnt, 1);
        idle();
        check("err_idle_werr", bus.word_err, 0);
        check("err_hold_frame_err", bus.frame_err, 1);

        // Abort with a word mid-frame, then three more words
        apply(1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_pre_done", bus.frame_done, 0);
        apply(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_w0_valid", bus.out_valid, 1);
        check("abort_w0_done", bus.frame_done, 0);
        check("abort_w0_busy", bus.busy, 1);
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_w1_done", bus.frame_done, 0);
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_w2_done", bus.frame_done, 0);
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_w3_done", bus.frame_done, 1);
        check("abort_frame_par", bus.frame_par, 1);
        check("abort_frame_err", bus.frame_err, 0);
        check("abort_err_cnt", bus.err_cnt, 1);

        // Asynchronous reset mid-frame, away from any clock edge
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_pre_valid", bus.out_valid, 1);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_err_cnt", bus.err_cnt, 0);
        check("mid_rst_frame_par", bus.frame_par, 0);
        check("mid_rst_out_par", bus.out_par, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_w0_done", bus.frame_done, 0);
        apply(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_w2_done", bus.frame_done, 0);
        apply(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_w3_done", bus.frame_done, 1);
        check("post_err_cnt", bus.err_cnt, 0);
        idle();

        // Saturation and clear on the CNT_W=2 instance
        check("sat_rst_err_cnt", bus2.err_cnt, 0);
        rst2 = 1'b0;
        @(negedge clk);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_e1", bus2.err_cnt, 1);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_e2", bus2.err_cnt, 2);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_e3", bus2.err_cnt, 3);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_e4", bus2.err_cnt, 3);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_e5", bus2.err_cnt, 3);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_alone", bus2.err_cnt, 0);
        apply(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clean_after_clr", bus2.err_cnt, 0);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("err_after_clr", bus2.err_cnt, 1);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_with_err", bus2.err_cnt, 1);
        check("clr_with_err_werr", bus2.word_err, 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
